// File: rtl/key_event_decoder.sv
// key_event_decoder: decodes two USB HID keycode words into debounced
// player-action levels and auto-repeating menu-key pulses, one update per frame.

// Per-key debounce: debounced state flips only after raw has disagreed
// with it for D consecutive frames. Frames flagged by hold are ignored.
module ked_debounce #(
  parameter int unsigned D = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic raw,
  output logic deb,
  output logic deb_next
);
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic       flip;

  // Flip decision for this edge, also exported so the repeat logic sees the edge early
  always_comb begin
    cnt_inc  = cnt + 4'd1;
    flip     = !hold && (raw != deb) && (cnt_inc == 4'(D));
    deb_next = flip ? raw : deb;
  end

  // Disagreement counter and debounced state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (!hold) begin
      if (raw == deb) begin
        cnt <= '0;
      end else if (flip) begin
        deb <= raw;
        cnt <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end
endmodule

// Per-menu-key auto-repeat: pulse on press, again after DELAY frames,
// then every RATE frames while held. Release always wins.
module ked_repeat #(
  parameter int unsigned DELAY = 30,
  parameter int unsigned RATE  = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic deb_next,
  output logic pulse
);
  typedef enum logic [1:0] {IDLE, WAIT_DELAY, WAIT_RATE} state_t;
  state_t     state;
  logic [7:0] rc;
  logic [7:0] rc_inc;

  always_comb rc_inc = rc + 8'd1;

  // Repeat FSM with registered pulse; frozen on rollover frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rc    <= '0;
      pulse <= 1'b0;
    end else if (hold) begin
      pulse <= 1'b0;
    end else if (!deb_next) begin
      state <= IDLE;
      rc    <= '0;
      pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pulse <= 1'b1;
          rc    <= '0;
          state <= WAIT_DELAY;
        end
        WAIT_DELAY: begin
          if (rc_inc == 8'(DELAY)) begin
            pulse <= 1'b1;
            rc    <= '0;
            state <= WAIT_RATE;
          end else begin
            pulse <= 1'b0;
            rc    <= rc_inc;
          end
        end
        WAIT_RATE: begin
          if (rc_inc == 8'(RATE)) begin
            pulse <= 1'b1;
            rc    <= '0;
          end else begin
            pulse <= 1'b0;
            rc    <= rc_inc;
          end
        end
        default: begin
          pulse <= 1'b0;
          rc    <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

module key_event_decoder #(
  parameter logic [7:0]  P1_LEFT         = 8'h04,
  parameter logic [7:0]  P1_RIGHT        = 8'h07,
  parameter logic [7:0]  P1_JUMP         = 8'h1A,
  parameter logic [7:0]  P1_KICK         = 8'h2C,
  parameter logic [7:0]  P2_LEFT         = 8'h50,
  parameter logic [7:0]  P2_RIGHT        = 8'h4F,
  parameter logic [7:0]  P2_JUMP         = 8'h52,
  parameter logic [7:0]  P2_KICK         = 8'h10,
  parameter logic [7:0]  MENU_1          = 8'h1E,
  parameter logic [7:0]  MENU_2          = 8'h1F,
  parameter logic [7:0]  MENU_R          = 8'h15,
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned REPEAT_DELAY    = 30,
  parameter int unsigned REPEAT_RATE     = 6
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycode0,
  input  logic [31:0] keycode1,
  output logic [3:0]  p1_actions,
  output logic [3:0]  p2_actions,
  output logic [2:0]  menu_held,
  output logic [2:0]  menu_pulse,
  output logic        rollover_err
);
  localparam int NUM_KEYS  = 11;
  localparam int NUM_BYTES = 8;
  localparam int NUM_MENU  = 3;
  localparam int MENU_BASE = 8;

  // Key index order: p1 {L,R,J,K}, p2 {L,R,J,K}, menu {1,2,R}
  localparam logic [NUM_KEYS-1:0][7:0] CODES = {
    MENU_R, MENU_2, MENU_1,
    P2_KICK, P2_JUMP, P2_RIGHT, P2_LEFT,
    P1_KICK, P1_JUMP, P1_RIGHT, P1_LEFT
  };

  logic [NUM_BYTES-1:0][7:0] kbytes;
  logic [NUM_KEYS-1:0]       raw;
  logic [NUM_KEYS-1:0]       deb;
  logic [NUM_KEYS-1:0]       deb_next;
  logic                      rollover;

  assign kbytes = {keycode1, keycode0};

  // Raw key match across all 8 usage bytes; usage 0x00 means empty slot
  always_comb begin
    raw      = '0;
    rollover = 1'b0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (kbytes[b] == 8'h01) rollover = 1'b1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (CODES[k] != 8'h00 && kbytes[b] == CODES[k]) raw[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    ked_debounce #(.D(DEBOUNCE_FRAMES)) u_deb (
      .clk      (frame_clk),
      .rst      (Reset),
      .hold     (rollover),
      .raw      (raw[k]),
      .deb      (deb[k]),
      .deb_next (deb_next[k])
    );
  end

  for (genvar m = 0; m < NUM_MENU; m++) begin : g_menu
    ked_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_rep (
      .clk      (frame_clk),
      .rst      (Reset),
      .hold     (rollover),
      .deb_next (deb_next[MENU_BASE+m]),
      .pulse    (menu_pulse[m])
    );
  end

  assign p1_actions = deb[3:0];
  assign p2_actions = deb[7:4];
  assign menu_held  = deb[10:8];

  // Rollover flag registered per frame; drops on the next clean frame
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) rollover_err <= 1'b0;
    else       rollover_err <= rollover;
  end
endmodule
